tank_pump_controller: RTL and testbench
=======================================

Name: tank_pump_controller

Overview:
- Downstream consumer of the H/M/L tank-level register outputs in the irrigation box.
- Synchronises and debounces the three level bits, then decodes them into a validated level.
- A supervisory FSM drives the fill pump, the irrigation valve and the `ud` direction bit.
- Detects invalid sensor codes and fill timeouts, and latches a fault code until cleared.

Parameters:
- DEBOUNCE, 4, consecutive cycles a synchronised level code must stay unchanged before it is accepted (1..15).
- FILL_TIMEOUT, 1000, cycles allowed in FILL without an accepted level increase before a pump fault.
- TW, 10, width of the timeout counter; FILL_TIMEOUT < 2^TW.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  operator enable (level, not pulse).
- clr_fault  in  1  fault acknowledge.
- H  in  1  high-level bit from the level register.
- M  in  1  mid-level bit from the level register.
- L  in  1  low-level bit from the level register.
- pump  out  1  fill pump on.
- valve  out  1  irrigation valve open.
- ud  out  1  direction to the level register: 1 = filling, 0 = draining.
- level  out  2  accepted level: 0 empty, 1 low, 2 mid, 3 full.
- alarm  out  1  fault active.
- err_code  out  2  0 none, 1 invalid sensor code, 2 fill timeout.

Behaviour:
- **Reset.** Asynchronous active-high reset applies immediately on rst=1, independent of clk. All registers clear.
  - Outputs: pump=0, valve=0, ud=0, level=0, alarm=0, err_code=0.
  - FSM returns to IDLE.
  - Synchroniser and debounce/timeout counters clear.
- **Synchroniser.** {H,M,L} passes through a 2-flop synchroniser.
- **Debounce counter.**
  - Reloads to 0 whenever the synchronised code differs from the previous cycle's code.
  - Otherwise increments, saturating at DEBOUNCE.
  - Accepted code updates on the cycle the count reaches DEBOUNCE-1 with no change.
  - Latency from a stable input change to `level` update is 2+DEBOUNCE cycles.
  - A glitch shorter than DEBOUNCE cycles never changes `level`.
- **Decode.** Thermometer code only: 000→0, 001→1, 011→2, 111→3.
  - Any other accepted code (010, 100, 101, 110) raises sensor_fault.
  - On sensor_fault, `level` holds its last valid value.
- **FSM states.** IDLE, FILL, IRRIGATE, FAULT. All outputs are registered and reflect the state entered on the same edge.
  - **Priority in every non-FAULT state:** sensor_fault > start=0 > the state's own transitions.
  - **IDLE:**
    - pump=0, valve=0, ud=0.
    - start=1 and level≤1 → FILL.
    - start=1 and level≥2 → IRRIGATE.
  - **FILL:**
    - pump=1, ud=1, valve=(level≠0).
    - level==3 → IRRIGATE.
    - Timeout counter clears on entry and on every accepted level increase; otherwise it increments each cycle.
    - Counter reaching FILL_TIMEOUT → FAULT with err_code=2.
  - **IRRIGATE:**
    - pump=0, ud=0, valve=1.
    - level drops to ≤1 → FILL. This gives hysteresis: fill starts at low and stops at full.
  - **start=0** in FILL or IRRIGATE → IDLE on the next edge. Timeout counter clears.
  - **sensor_fault** in any state except FAULT → FAULT with err_code=1. It takes precedence over a simultaneous timeout.
  - **FAULT:**
    - pump=0, valve=0, ud=0, alarm=1.
    - err_code holds the first cause; later faults do not overwrite it.
    - Exits to IDLE only when clr_fault=1, start=0 and no sensor_fault is currently decoded.
    - On exit, alarm and err_code clear on that edge.
    - clr_fault while start=1 is ignored.
- **Reset mid-operation.** Reset in any state forces all outputs off immediately. After release, the block re-debounces from scratch: level reads 0 until a code is accepted.
- **Simultaneous events.** If level reaches 3 on the same cycle the timeout expires, the level increase wins → IRRIGATE.

Test Plan:
- **Reset/debounce.** After reset, drive HML=001 stable with start=0 → level=1 exactly 6 cycles later (DEBOUNCE=4); pump=0, valve=0.
- **Fill cycle.** HML=001, start=1 → FILL: pump=1, ud=1, valve=1. Step HML 011 then 111 (each held 20 cycles) → IRRIGATE after the 111 code is accepted: pump=0, valve=1, ud=0.
- **Hysteresis.** From IRRIGATE, drop HML 111→011 → stays IRRIGATE. Drop 011→001 → FILL, pump=1. Then 000 → valve=0, pump=1.
- **Glitch rejection and sensor fault.** In IRRIGATE, inject HML=101 for 3 cycles → no change. Hold 101 for 10 cycles → FAULT: alarm=1, err_code=1, all actuators 0. clr_fault with start=1 → stays in FAULT. start=0, HML=011, clr_fault=1 → IDLE, alarm=0.
- **Fill timeout.** FILL_TIMEOUT=50, HML held 001 in FILL → at cycle 50 FAULT with err_code=2, pump=0. An accepted 011 at cycle 30 instead restarts the count and no fault occurs.
- **Abort and async reset.** start=0 during FILL → IDLE next edge, pump=0. Asserting rst mid-FILL between clock edges → pump=0 immediately, level=0.

Source files
------------

// File: rtl/tank_pump_if.sv
// Bundles the operator controls, the H/M/L level bits and the actuator/status
// outputs of the tank pump controller into one port.
interface tank_pump_if;
  logic       start;
  logic       clr_fault;
  logic       H;
  logic       M;
  logic       L;
  logic       pump;
  logic       valve;
  logic       ud;
  logic [1:0] level;
  logic       alarm;
  logic [1:0] err_code;

  // Side that drives the controls and level bits and observes the controller
  modport master (
    output start, clr_fault, H, M, L,
    input  pump, valve, ud, level, alarm, err_code
  );

  // Controller side
  modport slave (
    input  start, clr_fault, H, M, L,
    output pump, valve, ud, level, alarm, err_code
  );
endinterface

// File: rtl/tank_pump_controller.sv
// Tank pump controller: synchronises and debounces the H/M/L level bits,
// decodes them into a validated level, and runs the fill/irrigate supervisor
// with sensor-code and fill-timeout fault latching.
module tank_pump_controller #(
  parameter int DEBOUNCE     = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int TW           = 10
) (
  input  logic        clk,
  input  logic        rst,
  tank_pump_if.slave  bus
);

  localparam logic [3:0]    DB_MAX   = 4'(DEBOUNCE);
  localparam logic [3:0]    DB_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [1:0]    ERR_NONE   = 2'd0;
  localparam logic [1:0]    ERR_SENSOR = 2'd1;
  localparam logic [1:0]    ERR_TMO    = 2'd2;

  typedef enum logic [1:0] {IDLE, FILL, IRRIGATE, FAULT} state_t;

  // Only thermometer codes describe a physical water level.
  function automatic logic code_valid(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b011) || (c == 3'b111);
  endfunction

  function automatic logic [1:0] code_to_level(input logic [2:0] c);
    case (c)
      3'b001:  return 2'd1;
      3'b011:  return 2'd2;
      3'b111:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [2:0]    sync_a_reg, sync_b_reg, code_prev_reg, acc_code_reg;
  logic [3:0]    db_cnt_reg, db_cnt_next;
  logic [1:0]    level_reg, level_next;
  logic          accept, sensor_fault, level_up;
  state_t        state_reg, state_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic [1:0]    err_reg, err_next;
  logic          pump_reg, valve_reg, ud_reg, alarm_reg;
  logic          pump_next, valve_next, ud_next, alarm_next;

  // Two-flop synchroniser plus a one-cycle history for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_reg    <= '0;
      sync_b_reg    <= '0;
      code_prev_reg <= '0;
    end else begin
      sync_a_reg    <= {bus.H, bus.M, bus.L};
      sync_b_reg    <= sync_a_reg;
      code_prev_reg <= sync_b_reg;
    end
  end

  // Stability counter; a code is accepted on the cycle the count reaches DEBOUNCE-1
  always_comb begin
    db_cnt_next = db_cnt_reg;
    if (sync_b_reg != code_prev_reg) begin
      db_cnt_next = '0;
    end else if (db_cnt_reg != DB_MAX) begin
      db_cnt_next = db_cnt_reg + 4'd1;
    end
    accept     = (db_cnt_next == DB_LAST);
    level_next = (accept && code_valid(sync_b_reg)) ? code_to_level(sync_b_reg) : level_reg;
    level_up   = (level_next > level_reg);
  end

  // The accepted code may be invalid; level keeps the last valid reading then
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_reg   <= '0;
      acc_code_reg <= '0;
      level_reg    <= '0;
    end else begin
      db_cnt_reg <= db_cnt_next;
      if (accept) begin
        acc_code_reg <= sync_b_reg;
      end
      level_reg <= level_next;
    end
  end

  assign sensor_fault = !code_valid(acc_code_reg);

  // Supervisor next state, timeout count, fault cause and registered outputs
  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    tmo_next   = '0;
    if (state_reg == FAULT) begin
      if (bus.clr_fault && !bus.start && !sensor_fault) begin
        state_next = IDLE;
        err_next   = ERR_NONE;
      end
    end else if (sensor_fault) begin
      state_next = FAULT;
      err_next   = ERR_SENSOR;
    end else if (!bus.start) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = (level_reg <= 2'd1) ? FILL : IRRIGATE;
        FILL: begin
          if (level_reg == 2'd3) begin
            state_next = IRRIGATE;
          end else if (level_up) begin
            tmo_next = '0;
          end else if (tmo_reg == TMO_LAST) begin
            state_next = FAULT;
            err_next   = ERR_TMO;
          end else begin
            tmo_next = tmo_reg + TW'(1);
          end
        end
        IRRIGATE: begin
          if (level_reg <= 2'd1) begin
            state_next = FILL;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    pump_next  = (state_next == FILL);
    ud_next    = (state_next == FILL);
    valve_next = (state_next == IRRIGATE) || ((state_next == FILL) && (level_next != 2'd0));
    alarm_next = (state_next == FAULT);
  end

  // Supervisor state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      tmo_reg   <= '0;
      err_reg   <= ERR_NONE;
      pump_reg  <= 1'b0;
      valve_reg <= 1'b0;
      ud_reg    <= 1'b0;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
      pump_reg  <= pump_next;
      valve_reg <= valve_next;
      ud_reg    <= ud_next;
      alarm_reg <= alarm_next;
    end
  end

  assign bus.pump     = pump_reg;
  assign bus.valve    = valve_reg;
  assign bus.ud       = ud_reg;
  assign bus.level    = level_reg;
  assign bus.alarm    = alarm_reg;
  assign bus.err_code = err_reg;

endmodule

// File: tb/tb_tank_pump_controller.sv
// Testbench for tank_pump_controller: directed stimulus, a cycle-level model
// built from the level/debounce/supervisor rules, and literal spot checks.
module tb_tank_pump_controller;

  localparam int DEB = 4;
  localparam int FT  = 50;

  localparam int S_IDLE  = 0;
  localparam int S_FILL  = 1;
  localparam int S_IRR   = 2;
  localparam int S_FAULT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tank_pump_if bus();

  tank_pump_controller #(.DEBOUNCE(DEB), .FILL_TIMEOUT(FT), .TW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int         m_state, m_level, m_age, m_err;
  logic [2:0] m_acc;
  logic       m_pump, m_valve, m_ud, m_alarm;
  logic [2:0] iq[$];
  logic [2:0] cq[$];

  function automatic int thermo(input logic [2:0] c);
    case (c)
      3'b000:  return 0;
      3'b001:  return 1;
      3'b011:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_level = 0; m_age = 0; m_err = 0; m_acc = 3'b000;
    m_pump = 0; m_valve = 0; m_ud = 0; m_alarm = 0;
    iq = {3'b000, 3'b000};
    cq = {3'b000};
  endtask

  task automatic model_step();
    logic [2:0] c;
    int run, new_level, ns, new_age, new_err;
    bit sf, up;
    // synchronised code is the input sampled two edges ago
    iq.push_back({bus.H, bus.M, bus.L});
    c = iq[iq.size() - 3];
    if (iq.size() > 3) void'(iq.pop_front());
    cq.push_back(c);
    if (cq.size() > DEB + 1) void'(cq.pop_front());
    run = 0;
    for (int i = cq.size() - 1; i >= 0; i--) begin
      if (cq[i] != c) break;
      run++;
    end
    sf = (thermo(m_acc) < 0);
    new_level = m_level;
    if (run == DEB) begin
      m_acc = c;
      if (thermo(c) >= 0) new_level = thermo(c);
    end
    up = (new_level > m_level);
    ns = m_state; new_age = 0; new_err = m_err;
    if (m_state == S_FAULT) begin
      if (bus.clr_fault && !bus.start && !sf) begin ns = S_IDLE; new_err = 0; end
    end else if (sf) begin
      ns = S_FAULT; new_err = 1;
    end else if (!bus.start) begin
      ns = S_IDLE;
    end else if (m_state == S_IDLE) begin
      ns = (m_level <= 1) ? S_FILL : S_IRR;
    end else if (m_state == S_FILL) begin
      if (m_level == 3) ns = S_IRR;
      else begin
        new_age = up ? 0 : m_age + 1;
        if (new_age == FT) begin ns = S_FAULT; new_err = 2; new_age = 0; end
      end
    end else begin
      if (m_level <= 1) ns = S_FILL;
    end
    m_state = ns; m_age = new_age; m_err = new_err; m_level = new_level;
    m_pump  = (ns == S_FILL);
    m_ud    = (ns == S_FILL);
    m_valve = (ns == S_IRR) || (ns == S_FILL && new_level != 0);
    m_alarm = (ns == S_FAULT);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic [7:0] act, exp;
        act = {bus.pump, bus.valve, bus.ud, bus.level, bus.alarm, bus.err_code};
        exp = {m_pump, m_valve, m_ud, 2'(m_level), m_alarm, 2'(m_err)};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model t=%0t: got pvu/lvl/al/err=%b expected %b", $time, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_hml(input logic [2:0] v);
    {bus.H, bus.M, bus.L} = v;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end else begin
      $display("check %s t=%0t: %h ok", name, $time, act);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clr_fault = 1'b0;
    set_hml(3'b000);
    tick(3);
    chk("reset_outs", 16'({bus.pump, bus.valve, bus.ud, bus.level, bus.alarm, bus.err_code}), 16'd0);
    #2 rst = 1'b0;
    tick(4);

    // debounce latency: level moves on the sixth edge
    set_hml(3'b001);
    tick(5); chk("deb_lat_5", 16'(bus.level), 16'd0);
    tick(1); chk("deb_lat_6", 16'(bus.level), 16'd1);
    chk("idle_actuators", 16'({bus.pump, bus.valve}), 16'd0);

    // fill cycle
    bus.start = 1'b1;
    tick(1); chk("fill_entry", 16'({bus.pump, bus.ud, bus.valve}), 16'b111);
    set_hml(3'b011);
    tick(20); chk("fill_mid", 16'({bus.level, bus.pump}), 16'({2'd2, 1'b1}));
    set_hml(3'b111);
    tick(20); chk("irr_entry", 16'({bus.pump, bus.valve, bus.ud, bus.level}), 16'({1'b0, 1'b1, 1'b0, 2'd3}));

    // hysteresis
    set_hml(3'b011);
    tick(10); chk("hyst_mid", 16'({bus.pump, bus.valve, bus.level}), 16'({1'b0, 1'b1, 2'd2}));
    set_hml(3'b001);
    tick(10); chk("hyst_low", 16'({bus.pump, bus.valve, bus.ud, bus.level}), 16'({1'b1, 1'b1, 1'b1, 2'd1}));
    set_hml(3'b000);
    tick(10); chk("fill_empty", 16'({bus.pump, bus.valve, bus.level}), 16'({1'b1, 1'b0, 2'd0}));
    set_hml(3'b111);
    tick(10); chk("refill", 16'({bus.pump, bus.valve, bus.level}), 16'({1'b0, 1'b1, 2'd3}));

    // glitch rejection and sensor fault
    set_hml(3'b101);
    tick(3);
    set_hml(3'b111);
    tick(10); chk("glitch", 16'({bus.alarm, bus.valve, bus.level}), 16'({1'b0, 1'b1, 2'd3}));
    set_hml(3'b101);
    tick(10); chk("sensor_fault", 16'({bus.alarm, bus.err_code, bus.pump, bus.valve, bus.ud, bus.level}),
                  16'({1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'd3}));
    bus.clr_fault = 1'b1;
    tick(3); chk("clr_ignored", 16'({bus.alarm, bus.err_code}), 16'({1'b1, 2'd1}));
    bus.start = 1'b0;
    set_hml(3'b011);
    tick(10); chk("fault_exit", 16'({bus.alarm, bus.err_code, bus.level, bus.pump}), 16'({1'b0, 2'd0, 2'd2, 1'b0}));
    bus.clr_fault = 1'b0;

    // fill timeout
    set_hml(3'b001);
    tick(8);
    bus.start = 1'b1;
    tick(1);  chk("tmo_entry", 16'(bus.pump), 16'd1);
    tick(49); chk("tmo_49", 16'({bus.alarm, bus.pump}), 16'({1'b0, 1'b1}));
    tick(1);  chk("tmo_fault", 16'({bus.alarm, bus.err_code, bus.pump}), 16'({1'b1, 2'd2, 1'b0}));
    bus.start = 1'b0;
    bus.clr_fault = 1'b1;
    tick(2); chk("tmo_clear", 16'({bus.alarm, bus.err_code}), 16'd0);
    bus.clr_fault = 1'b0;

    // accepted increase at cycle 30 restarts the count
    bus.start = 1'b1;
    tick(1);
    tick(24);
    set_hml(3'b011);
    tick(35); chk("tmo_restart", 16'({bus.alarm, bus.pump, bus.level}), 16'({1'b0, 1'b1, 2'd2}));

    // abort
    bus.start = 1'b0;
    tick(1); chk("abort", 16'({bus.pump, bus.ud, bus.valve}), 16'd0);

    // asynchronous reset mid-fill
    set_hml(3'b001);
    tick(8);
    bus.start = 1'b1;
    tick(3); chk("pre_reset_fill", 16'(bus.pump), 16'd1);
    #2 rst = 1'b1;
    #1 chk("async_rst", 16'({bus.pump, bus.valve, bus.ud, bus.level, bus.alarm, bus.err_code}), 16'd0);
    tick(2);
    #2 rst = 1'b0;
    tick(3); chk("rerun_lvl0", 16'(bus.level), 16'd0);
    tick(5); chk("rerun_lvl1", 16'(bus.level), 16'd1);
    bus.start = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
